truth_table_sequencer: RTL and testbench
========================================

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, 4, number of clk cycles each input vector is held before outputs are sampled. Legal range is 1..255.
REQ-002 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, reset: asynchronous, active-high.
REQ-004 Port start, input, 1, one-cycle request to begin a 16-row scan.
REQ-005 Port abort, input, 1, synchronous scan cancel.
REQ-006 Port w, x, y, z, output, 1 each, registered input vector driven to the breadboard stage; w is the MSB and z is the LSB.
REQ-007 Port f, input, 10, breadboard outputs f0..f9, with f[0] being f0.
REQ-008 Port row_valid, output, 1, captured row available.
REQ-009 Port row_ready, input, 1, consumer accepts the row.
REQ-010 Port row_index, output, 4, row number of the captured row; equals {w,x,y,z} at capture.
REQ-011 Port row_data, output, 10, f sampled for that row.
REQ-012 Port busy, output, 1, high whenever state is not IDLE.
REQ-013 Port done, output, 1, one-cycle pulse when the scan completes.

Function
REQ-014 States SHALL be IDLE, SETTLE, OUTPUT and DONE.
REQ-015 IDLE behaviour:
- start=1 loads index=0 and {w,x,y,z}=0, clears the settle count, and moves to SETTLE.
- start=0 stays in IDLE.
REQ-016 SETTLE lasts exactly SETTLE_CYCLES cycles.
- On its final edge, f is registered into row_data, row_index is loaded from index, and the state moves to OUTPUT.
REQ-017 OUTPUT behaviour:
- row_valid=1, with row_index and row_data held stable until the edge where row_valid and row_ready are both high.
REQ-018 On acceptance:
- index<15: index increments, {w,x,y,z} updates on the same edge, row_valid falls, and the state moves to SETTLE.
- index==15: row_valid falls and the state moves to DONE.
REQ-019 Index 15 SHALL NOT wrap to 0; exactly 16 rows are emitted per scan, and no counter overflow decides termination.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-021 start SHALL be ignored in every state except IDLE.
REQ-022 abort=1 in any non-IDLE state:
- Next edge: IDLE, row_valid=0, no done pulse, {w,x,y,z} held at its last value.
- abort has priority over acceptance and over start.
REQ-023 Latency and throughput:
- start sampled at edge k gives first row_valid high after edge k+1+SETTLE_CYCLES.
- With row_ready held high, rows arrive every SETTLE_CYCLES+1 cycles.
- A full scan takes 16*(SETTLE_CYCLES+1)+1 cycles from start to the done edge.
REQ-024 f SHALL be sampled only on the final SETTLE edge; changes on f at any other time have no effect.

Reset
REQ-025 rst=1 SHALL immediately, without a clock edge, force:
- state=IDLE and index=0;
- w=x=y=z=0;
- row_valid=0, row_index=0, row_data=0;
- busy=0, done=0.
REQ-026 Reset asserted mid-scan SHALL discard the pending row; the first start after release begins at row 0.

Structure
REQ-027 Package truth_table_pkg SHALL hold:
- the state enumeration;
- ROW_COUNT=16, INPUT_BITS=4, FUNC_BITS=10.
REQ-028 One sub-module, settle_timer, SHALL hold:
- an 8-bit down-counter, loaded with SETTLE_CYCLES-1;
- an expired flag that marks the final SETTLE cycle.
REQ-029 The parent SHALL contain the state machine, the index register and the row output register.

Verification
REQ-030 Stub f={6'b0,w,x,y,z}, SETTLE_CYCLES=4, row_ready=1, single start pulse -> expect:
- 16 rows, row_index 0..15, row_data[3:0]==row_index, rows 5 cycles apart;
- done pulses once, 81 cycles after start.
REQ-031 Hold row_ready=0 for 10 cycles while row 3 is valid -> row_valid stays 1, row_data/row_index stay unchanged, {w,x,y,z} stays 0011; the scan resumes after ready returns.
REQ-032 Pulse start during row 5 -> no restart; the scan still ends after row 15 with a single done.
REQ-033 Assert abort during SETTLE of row 7 -> IDLE next cycle, busy=0, no done; a new start produces row 0 first.
REQ-034 Assert rst asynchronously mid-SETTLE of row 9 -> all outputs 0 before the next clk edge; after release, start yields row_index 0.
REQ-035 SETTLE_CYCLES=1, ready high -> rows 2 cycles apart; exactly 16 rows, and no 17th row with index 0.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared types and sizes for the breadboard truth-table sequencer.
// One scan walks every 4-bit input vector and captures the 10 function outputs.
package truth_table_pkg;

    localparam int ROW_COUNT  = 16;
    localparam int INPUT_BITS = 4;
    localparam int FUNC_BITS  = 10;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        OUTPUT,
        DONE
    } seq_state_t;

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Settle timer: 8-bit down-counter whose expired flag marks the last SETTLE cycle.
// A cleared timer spends its first running cycle loading, so the opening row of a scan gets one extra cycle.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    logic [7:0] count;
    logic       armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
            armed <= 1'b0;
        end else if (clear) begin
            count <= 8'd0;
            armed <= 1'b0;
        end else if (load) begin
            count <= RELOAD;
            armed <= 1'b1;
        end else if (run) begin
            if (!armed) begin
                count <= RELOAD;
                armed <= 1'b1;
            end else if (count != 8'd0) begin
                count <= count - 8'd1;
            end
        end
    end

    assign expired = run && armed && (count == 8'd0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Drives each input vector onto the breadboard, waits for it to settle, and
// hands the sampled outputs to a consumer with a valid/ready row interface.
module truth_table_sequencer
    import truth_table_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  w,
    output logic                  x,
    output logic                  y,
    output logic                  z,
    input  logic [FUNC_BITS-1:0]  f,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic [INPUT_BITS-1:0] row_index,
    output logic [FUNC_BITS-1:0]  row_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [INPUT_BITS-1:0] LAST_ROW = INPUT_BITS'(ROW_COUNT - 1);

    seq_state_t            state;
    logic [INPUT_BITS-1:0] index;
    logic                  settle_expired;
    logic                  accept;

    assign accept = (state == OUTPUT) && row_ready && !abort;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state == IDLE) && start),
        .load    (accept),
        .run     (state == SETTLE),
        .expired (settle_expired)
    );

    // The index register is itself the vector driven to the breadboard.
    assign {w, x, y, z} = index;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            index     <= '0;
            row_valid <= 1'b0;
            row_index <= '0;
            row_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                row_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            index <= '0;
                            state <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (settle_expired) begin
                            row_data  <= f;
                            row_index <= index;
                            row_valid <= 1'b1;
                            state     <= OUTPUT;
                        end
                    end
                    OUTPUT: begin
                        if (row_ready) begin
                            row_valid <= 1'b0;
                            if (index == LAST_ROW) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                index <= index + 1'b1;
                                state <= SETTLE;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed scans with randomized breadboard truth tables; expected rows and
// timing come from the scan rules (row r of a scan starting at edge k).
module tb_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       row_ready = 1'b1;
    logic       w, x, y, z;
    logic [9:0] f;
    logic       row_valid;
    logic [3:0] row_index;
    logic [9:0] row_data;
    logic       busy, done;

    logic       start1 = 1'b0;
    logic       ready1 = 1'b1;
    logic       abort1 = 1'b0;
    logic       w1, x1, y1, z1;
    logic [9:0] f1;
    logic       row_valid1;
    logic [3:0] row_index1;
    logic [9:0] row_data1;
    logic       busy1, done1;

    logic [9:0] tbl  [16];
    logic [9:0] tbl1 [16];
    logic [9:0] noise = 10'd0;
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;

    // Breadboard stub: garbage while a row is presented, so late sampling shows up.
    assign f  = row_valid ? noise : tbl[{w, x, y, z}];
    assign f1 = tbl1[{w1, x1, y1, z1}];

    truth_table_sequencer #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .w(w), .x(x), .y(y), .z(z), .f(f),
        .row_valid(row_valid), .row_ready(row_ready),
        .row_index(row_index), .row_data(row_data),
        .busy(busy), .done(done)
    );

    truth_table_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .w(w1), .x(x1), .y(y1), .z(z1), .f(f1),
        .row_valid(row_valid1), .row_ready(ready1),
        .row_index(row_index1), .row_data(row_data1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int         arr_q[$];
    int         idx_q[$];
    logic [9:0] dat_q[$];
    int         done_q[$];
    logic       prev_v = 1'b0;
    int         arr1_q[$];
    int         idx1_q[$];
    logic [9:0] dat1_q[$];
    int         done1_q[$];
    logic       prev_v1 = 1'b0;

    always @(negedge clk) begin
        noise <= 10'($urandom);
        if (row_valid && !prev_v) arr_q.push_back(cyc);
        if (row_valid && row_ready) begin
            idx_q.push_back(int'(row_index));
            dat_q.push_back(row_data);
        end
        if (done) done_q.push_back(cyc);
        prev_v <= row_valid;
        if (row_valid1 && !prev_v1) arr1_q.push_back(cyc);
        if (row_valid1 && ready1) begin
            idx1_q.push_back(int'(row_index1));
            dat1_q.push_back(row_data1);
        end
        if (done1) done1_q.push_back(cyc);
        prev_v1 <= row_valid1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(output int t);
        tick();
        start = 1'b1;
        tick();
        t = cyc;
        start = 1'b0;
    endtask

    task automatic wait_row(input int idx, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            if (row_valid && (idx < 0 || int'(row_index) == idx)) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input bit second, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            if (!(second ? busy1 : busy)) ok = 1'b1;
        end
    endtask

    task automatic new_tables();
        for (int r = 0; r < 16; r++) begin
            tbl[r]  = {6'($urandom), 4'(r)};
            tbl1[r] = 10'($urandom);
        end
        arr_q.delete(); idx_q.delete(); dat_q.delete(); done_q.delete();
    endtask

    task automatic check_rows(input string tag);
        check({tag, "_rows"}, 32'(idx_q.size()), 32'd16);
        for (int r = 0; r < idx_q.size() && r < 16; r++) begin
            check($sformatf("%s_idx%0d", tag, r), 32'(idx_q[r]), 32'(r));
            check($sformatf("%s_dat%0d", tag, r), 32'(dat_q[r]), 32'(tbl[r]));
        end
        check({tag, "_done_cnt"}, 32'(done_q.size()), 32'd1);
    endtask

    initial begin
        int  t0;
        bit  ok;
        bit  stable;
        logic [9:0] held;

        new_tables();
        #1;
        check("rst_vec", 32'({w, x, y, z}), 32'd0);
        check("rst_valid", 32'(row_valid), 32'd0);
        check("rst_index", 32'(row_index), 32'd0);
        check("rst_data", 32'(row_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Full scan, ready held high: 16 rows every 5 cycles, done 81 cycles after start.
        new_tables();
        pulse_start(t0);
        check("a_busy", 32'(busy), 32'd1);
        wait_idle(1'b0, ok);
        check("a_finish", 32'(ok), 32'd1);
        check_rows("a");
        check("a_arr_cnt", 32'(arr_q.size()), 32'd16);
        for (int r = 0; r < arr_q.size() && r < 16; r++)
            check($sformatf("a_arr%0d", r), 32'(arr_q[r]), 32'(t0 + 5 + 5 * r));
        if (done_q.size() > 0) check("a_done_at", 32'(done_q[0]), 32'(t0 + 81));
        check("a_vec_end", 32'({w, x, y, z}), 32'd15);

        // Consumer stall on row 3, then a stray start during row 5.
        new_tables();
        pulse_start(t0);
        wait_row(3, ok);
        check("b_row3", 32'(ok), 32'd1);
        row_ready = 1'b0;
        held = row_data;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (!row_valid || row_index != 4'd3 || row_data != held || {w, x, y, z} != 4'd3)
                stable = 1'b0;
        end
        check("b_stall_stable", 32'(stable), 32'd1);
        check("b_stall_data", 32'(held), 32'(tbl[3]));
        row_ready = 1'b1;
        wait_row(5, ok);
        check("b_row5", 32'(ok), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(1'b0, ok);
        check("b_finish", 32'(ok), 32'd1);
        check_rows("b");

        // Abort while row 7 settles.
        new_tables();
        pulse_start(t0);
        wait_row(6, ok);
        check("c_row6", 32'(ok), 32'd1);
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("c_busy", 32'(busy), 32'd0);
        check("c_valid", 32'(row_valid), 32'd0);
        check("c_vec_held", 32'({w, x, y, z}), 32'd7);
        repeat (20) tick();
        check("c_no_done", 32'(done_q.size()), 32'd0);
        check("c_rows", 32'(idx_q.size()), 32'd7);
        pulse_start(t0);
        wait_row(-1, ok);
        check("c_restart", 32'(ok), 32'd1);
        check("c_first_idx", 32'(row_index), 32'd0);
        check("c_first_dat", 32'(row_data), 32'(tbl[0]));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("c_abort_out", 32'(busy), 32'd0);
        check("c_abort_done", 32'(done_q.size()), 32'd0);

        // Asynchronous reset while row 9 settles.
        new_tables();
        pulse_start(t0);
        wait_row(8, ok);
        check("d_row8", 32'(ok), 32'd1);
        tick(); tick();
        #1 rst = 1'b1;
        #1;
        check("d_vec", 32'({w, x, y, z}), 32'd0);
        check("d_valid", 32'(row_valid), 32'd0);
        check("d_index", 32'(row_index), 32'd0);
        check("d_data", 32'(row_data), 32'd0);
        check("d_busy", 32'(busy), 32'd0);
        check("d_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        new_tables();
        pulse_start(t0);
        wait_row(-1, ok);
        check("d_restart", 32'(ok), 32'd1);
        check("d_first_idx", 32'(row_index), 32'd0);
        wait_idle(1'b0, ok);
        check("d_finish", 32'(ok), 32'd1);
        check_rows("d");

        // Minimum settle time: rows 2 cycles apart, exactly 16 rows.
        tick();
        start1 = 1'b1;
        tick();
        t0 = cyc;
        start1 = 1'b0;
        wait_idle(1'b1, ok);
        check("e_finish", 32'(ok), 32'd1);
        repeat (10) tick();
        check("e_rows", 32'(idx1_q.size()), 32'd16);
        check("e_arr_cnt", 32'(arr1_q.size()), 32'd16);
        for (int r = 0; r < idx1_q.size() && r < 16; r++) begin
            check($sformatf("e_idx%0d", r), 32'(idx1_q[r]), 32'(r));
            check($sformatf("e_dat%0d", r), 32'(dat1_q[r]), 32'(tbl1[r]));
        end
        for (int r = 0; r < arr1_q.size() && r < 16; r++)
            check($sformatf("e_arr%0d", r), 32'(arr1_q[r]), 32'(t0 + 2 + 2 * r));
        check("e_done_cnt", 32'(done1_q.size()), 32'd1);
        if (done1_q.size() > 0) check("e_done_at", 32'(done1_q[0]), 32'(t0 + 33));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
